// File: rtl/boolean_pkg.sv
// Shared types and named truth tables for the three-input Boolean function unit.
package boolean_pkg;

    typedef logic [7:0] lut_t;
    typedef logic [2:0] idx_t;

    // Table bit i holds F for index {a,b,c} == i.
    localparam lut_t LUT_MUX  = 8'hCA;  // a·b + a'·c
    localparam lut_t LUT_AND3 = 8'h80;
    localparam lut_t LUT_OR3  = 8'hFE;
    localparam lut_t LUT_XOR3 = 8'h96;

    // Forms the table index with a as the most significant bit.
    function automatic idx_t make_idx(input logic a_v, input logic b_v, input logic c_v);
        return {a_v, b_v, c_v};
    endfunction

endpackage

// File: rtl/boolean_lut_cell.sv
// Purely combinational 8:1 select of a truth table by a 3-bit index.
module boolean_lut_cell
    import boolean_pkg::*;
(
    input  lut_t lut_i,
    input  idx_t idx_i,
    output logic f_o
);

    // Select the table bit addressed by the index.
    always_comb begin
        f_o = 1'b0;
        case (idx_i)
            3'd0:    f_o = lut_i[0];
            3'd1:    f_o = lut_i[1];
            3'd2:    f_o = lut_i[2];
            3'd3:    f_o = lut_i[3];
            3'd4:    f_o = lut_i[4];
            3'd5:    f_o = lut_i[5];
            3'd6:    f_o = lut_i[6];
            3'd7:    f_o = lut_i[7];
            default: f_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/boolean_eval.sv
// Reprogrammable three-input Boolean function: combinational F plus a
// registered copy f_q. The truth table resets to DEFAULT_LUT.
module boolean_eval
    import boolean_pkg::*;
#(
    parameter lut_t DEFAULT_LUT = LUT_MUX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       lut_we,
    input  logic [7:0] lut_wdata,
    output logic       F,
    output logic       f_q,
    output logic [7:0] lut_rdata
);

    lut_t lut_q;
    lut_t lut_d;
    idx_t idx_s;
    logic f_s;

    assign idx_s = make_idx(a, b, c);

    boolean_lut_cell u_cell (
        .lut_i (lut_q),
        .idx_i (idx_s),
        .f_o   (f_s)
    );

    assign F         = f_s;
    assign lut_rdata = lut_q;

    // Next table: take the write data when enabled, otherwise hold.
    always_comb begin
        lut_d = lut_q;
        if (lut_we) begin
            lut_d = lut_wdata;
        end else begin
            lut_d = lut_q;
        end
    end

    // Table and registered result; reset wins over a same-edge write, and
    // f_q samples F computed from the table as it was before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_q <= DEFAULT_LUT;
            f_q   <= 1'b0;
        end else begin
            lut_q <= lut_d;
            f_q   <= f_s;
        end
    end

endmodule

// File: tb/tb_boolean_eval.sv
// Directed and randomized checks of boolean_eval against a table-driven model.
module tb_boolean_eval;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c;
    logic       lut_we;
    logic [7:0] lut_wdata;
    logic       F;
    logic       f_q;
    logic [7:0] lut_rdata;

    int total = 0;
    int bad   = 0;

    // Reference state: the truth table and the expected registered output.
    int m_lut;
    int m_fq;

    boolean_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .lut_we    (lut_we),
        .lut_wdata (lut_wdata),
        .F         (F),
        .f_q       (f_q),
        .lut_rdata (lut_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int cur_idx();
        return 4 * int'(a) + 2 * int'(b) + int'(c);
    endfunction

    // Model value of F: bit idx of the table, by plain arithmetic.
    function automatic int model_f();
        return (m_lut / (1 << cur_idx())) % 2;
    endfunction

    // Advance the model over one rising edge using the inputs present now,
    // then wait for the edge and step 1 ns past it.
    task automatic cycle();
        if (rst_n === 1'b0) begin
            m_lut = 202;  // 8'hCA
            m_fq  = 0;
        end else begin
            m_fq = model_f();
            if (lut_we === 1'b1) m_lut = int'(lut_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idx(input int i);
        a = 1'((i / 4) % 2);
        b = 1'((i / 2) % 2);
        c = 1'(i % 2);
        #1;
    endtask

    bit def_seq [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit xor_seq [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
        lut_we = 1'b0; lut_wdata = 8'h00;
        m_lut = 0; m_fq = 0;
        #2;

        // Reset then default sweep.
        cycle();
        rst_n = 1'b1;
        check("reset_rdata", lut_rdata, 8'hCA);
        check("reset_fq", {7'd0, f_q}, 8'h00);
        check("reset_F", {7'd0, F}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            set_idx(i);
            check($sformatf("default_F_%0d", i), {7'd0, F}, {7'd0, def_seq[i]});
            cycle();
            check($sformatf("default_fq_%0d", i), {7'd0, f_q}, {7'd0, def_seq[i]});
        end
        check("default_rdata", lut_rdata, 8'hCA);

        // Registered path: idx 6 then 4.
        set_idx(6);
        check("reg_F6", {7'd0, F}, 8'h01);
        cycle();
        check("reg_fq6", {7'd0, f_q}, 8'h01);
        set_idx(4);
        check("reg_F4", {7'd0, F}, 8'h00);
        check("reg_fq_hold", {7'd0, f_q}, 8'h01);
        cycle();
        check("reg_fq4", {7'd0, f_q}, 8'h00);

        // Reprogram to XOR3 and sweep.
        lut_we = 1'b1; lut_wdata = 8'h96;
        cycle();
        lut_we = 1'b0;
        check("xor_rdata", lut_rdata, 8'h96);
        for (int i = 0; i < 8; i++) begin
            set_idx(i);
            check($sformatf("xor_F_%0d", i), {7'd0, F}, {7'd0, xor_seq[i]});
            cycle();
        end

        // Write/sample collision on the default table.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        set_idx(2);
        lut_we = 1'b1; lut_wdata = 8'hFF;
        cycle();
        lut_we = 1'b0;
        check("coll_fq_old", {7'd0, f_q}, 8'h00);
        check("coll_F_new", {7'd0, F}, 8'h01);
        cycle();
        check("coll_fq_new", {7'd0, f_q}, 8'h01);

        // Reset beats a same-edge write.
        lut_we = 1'b1; lut_wdata = 8'h00; rst_n = 1'b0;
        cycle();
        lut_we = 1'b0; rst_n = 1'b1;
        check("prio_rdata", lut_rdata, 8'hCA);
        check("prio_fq", {7'd0, f_q}, 8'h00);

        // Reset mid-operation after a write.
        lut_we = 1'b1; lut_wdata = 8'hFF;
        cycle();
        lut_we = 1'b0;
        set_idx(0);
        check("mid_F_before", {7'd0, F}, 8'h01);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_F_after", {7'd0, F}, 8'h00);
        check("mid_rdata", lut_rdata, 8'hCA);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            set_idx(int'($urandom_range(0, 7)));
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_wdata = 8'($urandom);
            rst_n     = ($urandom_range(0, 31) != 0);
            #1;
            check("rand_F", {7'd0, F}, 8'(model_f()));
            cycle();
            check("rand_fq", {7'd0, f_q}, 8'(m_fq));
            check("rand_rdata", lut_rdata, 8'(m_lut));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
